signal_conditioner: RTL and testbench

- Parametrised, multi-channel successor to the single-wire input-to-output pass-through.
- Each channel:
  - synchronises an asynchronous input (button, switch, external pin) into the clk domain;
  - debounces it with a stability counter;
  - drives a clean level output plus single-cycle rise/fall event pulses.
- Sits between board pins and blink/LED or user logic.

---
 rtl/signal_conditioner.sv | 116 +++++++++++
 tb/tb_signal_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_conditioner.sv
// ----------------------------------------------------------------------------
// signal_conditioner
//
// Multi-channel input conditioner. Every channel synchronises a raw
// asynchronous input into the clk domain, debounces it with a stability
// counter and produces a clean level plus single-cycle rise/fall pulses.
// Channels share no state.
//
// Parameters:
//   CHANNELS        number of independent channels (>=1)
//   SYNC_STAGES     flops per synchroniser chain (>=2)
//   DEBOUNCE_CYCLES consecutive mismatching cycles needed to accept a new
//                   level (>=1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   inSignal   in   [CHANNELS] raw asynchronous inputs
//   outSignal  out  [CHANNELS] debounced level (or toggle state, see below)
//   risePulse  out  [CHANNELS] one-cycle pulse on accepted 0->1
//   fallPulse  out  [CHANNELS] one-cycle pulse on accepted 1->0
//
// Optional build macro SIGNAL_CONDITIONER_TOGGLE_EN: outSignal becomes a
// per-channel toggle register that flips on every accepted rising edge
// (push-button on/off). Pulses still follow the internal debounced level.
// ----------------------------------------------------------------------------
module signal_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] inSignal,
    output logic [CHANNELS-1:0] outSignal,
    output logic [CHANNELS-1:0] risePulse,
    output logic [CHANNELS-1:0] fallPulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] w_synced;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= inSignal;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          r_stable;
        logic          r_rise;
        logic          r_fall;
        logic          w_accept;

        // Terminal count reached while still mismatching: this edge is the
        // DEBOUNCE_CYCLES-th consecutive mismatch, so the new level is taken.
        assign w_accept = (w_synced[g] != r_stable) && (r_cnt == TC);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_synced[g] == r_stable) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_stable <= w_synced[g];
                    r_cnt    <= '0;
                    r_rise   <= w_synced[g];
                    r_fall   <= ~w_synced[g];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign risePulse[g] = r_rise;
        assign fallPulse[g] = r_fall;

`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
        logic r_toggle;

        // Flips on the same edge that raises risePulse, so the visible
        // output changes in the cycle the pulse is high.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_toggle <= 1'b0;
            end else if (w_accept && w_synced[g]) begin
                r_toggle <= ~r_toggle;
            end
        end

        assign outSignal[g] = r_toggle;
`else
        assign outSignal[g] = r_stable;
`endif
    end

endmodule

// File: tb/tb_signal_conditioner.sv
// ----------------------------------------------------------------------------
// tb_signal_conditioner
//
// Directed bench for signal_conditioner with CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change 1 ns after a rising edge, so the next
// rising edge is "edge 1"; outputs are sampled 1 ns after each edge. With
// these parameters an accepted change appears on edge 6.
// ----------------------------------------------------------------------------
module tb_signal_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] inSignal;
    logic [3:0] outSignal;
    logic [3:0] risePulse;
    logic [3:0] fallPulse;

    int checks = 0;
    int errors = 0;

`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
    logic [3:0] tog_m = 4'h0;
`endif

    signal_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .inSignal  (inSignal),
        .outSignal (outSignal),
        .risePulse (risePulse),
        .fallPulse (fallPulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outSignal given the expected debounced level and rise pulses.
    function automatic logic [3:0] exp_o(input logic [3:0] lvl, input logic [3:0] rise);
`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
        tog_m = tog_m ^ rise;
        return tog_m;
`else
        return lvl | (rise & 4'h0);
`endif
    endfunction

    task automatic test_reset();
        logic [11:0] exp;
        reset_n  = 1'b0;
        inSignal = 4'hF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if ({outSignal, risePulse, fallPulse} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold e=%0d got=%h exp=000", e, {outSignal, risePulse, fallPulse});
            end
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp[11:8] = exp_o((e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0);
            exp[7:4]  = (e == 6) ? 4'hF : 4'h0;
            exp[3:0]  = 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL reset_release e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
        // all four fall together
        inSignal = 4'h0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp[11:8] = exp_o((e >= 6) ? 4'h0 : 4'hF, 4'h0);
            exp[7:4]  = 4'h0;
            exp[3:0]  = (e == 6) ? 4'hF : 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL multi_fall e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [11:0] exp;
        inSignal = 4'h1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp[11:8] = exp_o((e >= 6) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0);
            exp[7:4]  = (e == 6) ? 4'h1 : 4'h0;
            exp[3:0]  = 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL step_rise e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
        inSignal = 4'h0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp[11:8] = exp_o((e >= 6) ? 4'h0 : 4'h1, 4'h0);
            exp[7:4]  = 4'h0;
            exp[3:0]  = (e == 6) ? 4'h1 : 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL step_fall e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [11:0] exp;
        logic [3:0]  hold_o;
        hold_o = outSignal;
        // three cycles high: rejected
        for (int e = 1; e <= 12; e++) begin
            inSignal = (e <= 3) ? 4'h2 : 4'h0;
            tick();
            exp = {hold_o, 8'h00};
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL glitch3 e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
        // exactly four cycles high: accepted for four cycles
        for (int e = 1; e <= 14; e++) begin
            inSignal = (e <= 4) ? 4'h2 : 4'h0;
            tick();
            exp[11:8] = exp_o((e >= 6 && e < 10) ? 4'h2 : 4'h0, (e == 6) ? 4'h2 : 4'h0);
            exp[7:4]  = (e == 6) ? 4'h2 : 4'h0;
            exp[3:0]  = (e == 10) ? 4'h2 : 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL glitch4 e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] exp;
        for (int e = 1; e <= 20; e++) begin
            inSignal = (e > 10 || (e % 2) == 1) ? 4'h4 : 4'h0;
            tick();
            exp[11:8] = exp_o((e >= 16) ? 4'h4 : 4'h0, (e == 16) ? 4'h4 : 4'h0);
            exp[7:4]  = (e == 16) ? 4'h4 : 4'h0;
            exp[3:0]  = 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL bounce e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        logic [3:0]  hold_o;
        hold_o   = outSignal;
        inSignal = 4'hC;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp = {hold_o, 8'h00};
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL mid_precount e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
        reset_n = 1'b0;
`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
        tog_m = 4'h0;
`endif
        #1;
        checks++;
        if ({outSignal, risePulse, fallPulse} !== 12'h000) begin
            errors++;
            $display("FAIL mid_async_clear got=%h exp=000", {outSignal, risePulse, fallPulse});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp[11:8] = exp_o((e >= 6) ? 4'hC : 4'h0, (e == 6) ? 4'hC : 4'h0);
            exp[7:4]  = (e == 6) ? 4'hC : 4'h0;
            exp[3:0]  = 4'h0;
            checks++;
            if ({outSignal, risePulse, fallPulse} !== exp) begin
                errors++;
                $display("FAIL mid_release e=%0d got=%h exp=%h", e, {outSignal, risePulse, fallPulse}, exp);
            end
        end
    endtask

`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
    task automatic test_toggle();
        logic exp_b;
        exp_b = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            inSignal = 4'hD;
            for (int e = 1; e <= 8; e++) begin
                tick();
                if (e == 6) exp_b = ~exp_b;
            end
            checks++;
            if (outSignal[0] !== exp_b) begin
                errors++;
                $display("FAIL toggle_press p=%0d got=%b exp=%b", p, outSignal[0], exp_b);
            end
            inSignal = 4'hC;
            for (int e = 1; e <= 8; e++) tick();
            checks++;
            if (outSignal[0] !== exp_b) begin
                errors++;
                $display("FAIL toggle_release p=%0d got=%b exp=%b", p, outSignal[0], exp_b);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_reset_mid();
`ifdef SIGNAL_CONDITIONER_TOGGLE_EN
        test_toggle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
